// File: rtl/race_pkg.sv
// race_pkg: shared state encoding, countdown start value and field widths for the race controller
package race_pkg;
  typedef enum logic [1:0] {IDLE, COUNTDOWN, RACE, FINISHED} state_t;
  localparam logic [1:0] CD_START = 2'd3;
  localparam int SPEED_W = 4;
  localparam int TIME_W = 16;
endpackage

// File: rtl/frame_tick.sv
// frame_tick: vsync rising-edge detector producing a one-cycle frame tick
// Ports: clk, reset (sync, active-low), vsync_in (raw frame sync), tick (one cycle per vsync rise)
module frame_tick (
  input  logic clk,
  input  logic reset,
  input  logic vsync_in,
  output logic tick
);
  logic vsync_q;
  always_ff @(posedge clk)
    if (!reset) vsync_q <= 1'b0;
    else vsync_q <= vsync_in;
  assign tick = vsync_in & ~vsync_q;
endmodule

// File: rtl/race_controller.sv
// race_controller: countdown / race / finish sequencer driving scroll position and speed per frame
// Ports: clk, reset (sync, active-low), vsync_in, start (pulse), throttle (level);
//        position (scroll offset), speed, countdown (3..1, 0 otherwise), race_active,
//        finished (one-cycle pulse), race_time (frames raced).
// Optional: define RACE_TIMER_EN to build the race_time counter; otherwise race_time is tied to 0.
module race_controller
  import race_pkg::*;
#(
  parameter int FINISH_DIST = 1380,
  parameter int MAX_SPEED = 15,
  parameter int COUNT_FRAMES = 60
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               vsync_in,
  input  logic               start,
  input  logic               throttle,
  output logic [31:0]        position,
  output logic [SPEED_W-1:0] speed,
  output logic [1:0]         countdown,
  output logic               race_active,
  output logic               finished,
  output logic [TIME_W-1:0]  race_time
);
  localparam int FC_W = (COUNT_FRAMES > 1) ? $clog2(COUNT_FRAMES) : 1;
  state_t state, n_state;
  logic tick;
  logic [FC_W-1:0] fc, n_fc;
  logic [31:0] n_pos, sum;
  logic [SPEED_W-1:0] n_speed, sp_nx;
  logic [1:0] n_cd;
  logic n_fin;
  frame_tick u_tick (
    .clk(clk),
    .reset(reset),
    .vsync_in(vsync_in),
    .tick(tick)
  );
  assign sp_nx = throttle ? ((speed >= SPEED_W'(MAX_SPEED)) ? SPEED_W'(MAX_SPEED) : speed + SPEED_W'(1))
                          : ((speed == '0) ? '0 : speed - SPEED_W'(1));
  assign sum = position + 32'(sp_nx);
  always_comb begin
    n_state = state;
    n_pos = position;
    n_speed = speed;
    n_cd = countdown;
    n_fc = fc;
    n_fin = 1'b0;
    case (state)
      IDLE, FINISHED: begin
        if (state == IDLE) begin
          n_pos = '0;
          n_speed = '0;
        end
        // start has priority over a coincident tick, which is simply dropped
        if (start) begin
          n_state = COUNTDOWN;
          n_pos = '0;
          n_speed = '0;
          n_cd = CD_START;
          n_fc = '0;
        end
      end
      COUNTDOWN: begin
        if (tick) begin
          n_fc = (fc == FC_W'(COUNT_FRAMES - 1)) ? '0 : fc + FC_W'(1);
          if (fc == FC_W'(COUNT_FRAMES - 1)) begin
            n_cd = countdown - 2'd1;
            n_state = (countdown == 2'd1) ? RACE : COUNTDOWN;
          end
        end
      end
      RACE: begin
        if (tick) begin
          n_pos = (sum >= 32'(FINISH_DIST)) ? 32'(FINISH_DIST) : sum;
          n_speed = (sum >= 32'(FINISH_DIST)) ? '0 : sp_nx;
          n_fin = (sum >= 32'(FINISH_DIST));
          n_state = (sum >= 32'(FINISH_DIST)) ? FINISHED : RACE;
        end
      end
      default: n_state = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!reset) begin
      state <= IDLE;
      position <= '0;
      speed <= '0;
      countdown <= '0;
      fc <= '0;
      race_active <= 1'b0;
      finished <= 1'b0;
    end else begin
      state <= n_state;
      position <= n_pos;
      speed <= n_speed;
      countdown <= n_cd;
      fc <= n_fc;
      race_active <= (n_state == RACE);
      finished <= n_fin;
    end
`ifdef RACE_TIMER_EN
  always_ff @(posedge clk)
    if (!reset) race_time <= '0;
    else if (state != COUNTDOWN && n_state == COUNTDOWN) race_time <= '0;
    else if (state == RACE && tick && race_time != '1) race_time <= race_time + TIME_W'(1);
`else
  assign race_time = '0;
`endif
endmodule

// File: tb/tb_race_controller.sv
// tb_race_controller: directed checks of countdown, acceleration, decay, finish saturation and reset abort
module tb_race_controller;
  logic clk = 1'b0, reset = 1'b0, vsync_in = 1'b0, start = 1'b0, throttle = 1'b0;
  logic [31:0] pos_a, pos_b;
  logic [3:0] spd_a, spd_b;
  logic [1:0] cd_a, cd_b;
  logic act_a, act_b, fin_a, fin_b;
  logic [15:0] rt_a, rt_b;
  int total = 0, bad = 0, fin_cnt = 0, mpos, mspd;
`ifdef RACE_TIMER_EN
  localparam bit TMR = 1'b1;
`else
  localparam bit TMR = 1'b0;
`endif
  race_controller #(.FINISH_DIST(1380), .MAX_SPEED(15), .COUNT_FRAMES(4)) dut_a (
    .clk(clk), .reset(reset), .vsync_in(vsync_in), .start(start), .throttle(throttle),
    .position(pos_a), .speed(spd_a), .countdown(cd_a), .race_active(act_a),
    .finished(fin_a), .race_time(rt_a)
  );
  race_controller #(.FINISH_DIST(100), .MAX_SPEED(15), .COUNT_FRAMES(4)) dut_b (
    .clk(clk), .reset(reset), .vsync_in(vsync_in), .start(start), .throttle(throttle),
    .position(pos_b), .speed(spd_b), .countdown(cd_b), .race_active(act_b),
    .finished(fin_b), .race_time(rt_b)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (fin_b) fin_cnt++;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic frame();
    @(negedge clk) vsync_in = 1'b1;
    @(negedge clk);
    @(negedge clk) vsync_in = 1'b0;
    @(negedge clk);
  endtask
  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask
  task automatic countdown_to_race();
    pulse_start();
    repeat (12) frame();
  endtask
  initial begin
    bit pat [11] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 1, 0};
    repeat (2) @(negedge clk);
    chk("rst_pos", pos_a, 0);
    chk("rst_spd", 32'(spd_a), 0);
    chk("rst_cd", 32'(cd_a), 0);
    chk("rst_act", 32'(act_a), 0);
    chk("rst_fin", 32'(fin_a), 0);
    chk("rst_time", 32'(rt_a), 0);
    reset = 1'b1;
    pulse_start();
    chk("cd_start", 32'(cd_a), 3);
    for (int k = 1; k <= 12; k++) begin
      frame();
      chk($sformatf("cd_t%0d", k), 32'(cd_a), (k < 4) ? 3 : (k < 8) ? 2 : (k < 12) ? 1 : 0);
      chk($sformatf("act_t%0d", k), 32'(act_a), 32'(k == 12));
    end
    throttle = 1'b1;
    mpos = 0;
    mspd = 0;
    for (int k = 1; k <= 20; k++) begin
      mspd = (mspd < 15) ? mspd + 1 : 15;
      mpos += mspd;
      frame();
      chk($sformatf("acc_spd%0d", k), 32'(spd_a), 32'(mspd));
      chk($sformatf("acc_pos%0d", k), pos_a, 32'(mpos));
    end
    chk("acc_total", pos_a, 195);
    chk("fin_pos", pos_b, 100);
    chk("fin_spd", 32'(spd_b), 0);
    chk("fin_pulses", 32'(fin_cnt), 1);
    chk("fin_act", 32'(act_b), 0);
    chk("fin_time", 32'(rt_b), TMR ? 14 : 0);
    throttle = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      mspd--;
      mpos += mspd;
      frame();
      chk($sformatf("dec_spd%0d", k), 32'(spd_a), 32'(mspd));
      chk($sformatf("dec_pos%0d", k), pos_a, 32'(mpos));
    end
    chk("dec_total", pos_a, 300);
    repeat (3) frame();
    chk("coast_pos", pos_a, 300);
    chk("coast_spd", 32'(spd_a), 0);
    chk("hold_pos", pos_b, 100);
    chk("race_time_a", 32'(rt_a), TMR ? 38 : 0);
    pulse_start();
    chk("ign_cd", 32'(cd_a), 0);
    chk("ign_act", 32'(act_a), 1);
    chk("restart_cd", 32'(cd_b), 3);
    chk("restart_pos", pos_b, 0);
    chk("restart_time", 32'(rt_b), 0);
    @(negedge clk) reset = 1'b0;
    @(negedge clk) reset = 1'b1;
    countdown_to_race();
    for (int i = 0; i < 11; i++) begin
      throttle = pat[i];
      frame();
    end
    throttle = 1'b0;
    chk("mid_pos", pos_a, 50);
    chk("mid_spd", 32'(spd_a), 5);
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    chk("abort_pos", pos_a, 0);
    chk("abort_spd", 32'(spd_a), 0);
    chk("abort_act", 32'(act_a), 0);
    chk("abort_cd", 32'(cd_a), 0);
    chk("abort_time", 32'(rt_a), 0);
    reset = 1'b1;
    @(negedge clk) begin
      start = 1'b1;
      vsync_in = 1'b1;
    end
    @(negedge clk) start = 1'b0;
    @(negedge clk) vsync_in = 1'b0;
    @(negedge clk);
    chk("fresh_cd", 32'(cd_a), 3);
    repeat (2) frame();
    pulse_start();
    frame();
    chk("cd_ign_start", 32'(cd_a), 3);
    frame();
    chk("cd_after4", 32'(cd_a), 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
